// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and helpers for the adder-sharing arbiter (package add_arb_pkg).
package add_arb_pkg;

    localparam int WORD_W = 16;

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    // Round-robin successor of a requester index.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
        return (ptr + 32'd1 >= nreq) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bus between the datapath clients (master) and the shared adder arbiter (slave).
interface adder_share_arbiter_if
    import add_arb_pkg::*;
    #(parameter int NREQ = 4, parameter int ID_W = 2) ();

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*WORD_W-1:0] req_a;
    logic [NREQ*WORD_W-1:0] req_b;
    logic [NREQ-1:0]        req_cin;
    logic [NREQ-1:0]        req_last;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WORD_W-1:0]      rsp_y;
    logic                   rsp_co;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_co
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_co
    );

endinterface

// File: rtl/adder_16bit.sv
// The single shared combinational 16-bit adder core.
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        Cin,
    output logic [15:0] y,
    output logic        Co
);

    assign {Co, y} = 17'(a) + 17'(b) + 17'(Cin);

endmodule

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker; when locked only lock_id can win.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [ID_W-1:0] ptr,
    input  logic            lock,
    input  logic [ID_W-1:0] lock_id,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        gnt_onehot = '0;
        gnt_id     = '0;
        gnt_any    = 1'b0;
        idx        = '0;
        if (lock) begin
            if (req_valid[lock_id]) begin
                gnt_onehot[lock_id] = 1'b1;
                gnt_id              = lock_id;
                gnt_any             = 1'b1;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = ID_W'((int'(ptr) + k) % NREQ);
                if (!gnt_any && req_valid[idx]) begin
                    gnt_onehot[idx] = 1'b1;
                    gnt_id          = idx;
                    gnt_any         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one adder_16bit among NREQ requesters with a one-deep response slot.
// Build option ADD_ARB_CARRY_CHAIN_EN chains consecutive beats of one requester through carry_q.
module adder_share_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input logic                  clk,
    input logic                  rst,
    adder_share_arbiter_if.slave bus
);

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   lock_id;
    logic              carry_q;

    logic [NREQ-1:0]   gnt_onehot;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_any;
    logic              slot_free;
    logic              accept;

    logic [WORD_W-1:0] add_a;
    logic [WORD_W-1:0] add_b;
    logic [WORD_W-1:0] add_y;
    logic              add_cin;
    logic              add_co;

    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [WORD_W-1:0] rsp_y_q;
    logic              rsp_co_q;

    rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
        .req_valid  (bus.req_valid),
        .ptr        (ptr),
        .lock       (state == ST_LOCK),
        .lock_id    (lock_id),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id),
        .gnt_any    (gnt_any)
    );

    // Reset gates the accept so no beat is consumed while the block is being cleared.
    assign slot_free     = !rsp_valid_q || bus.rsp_ready;
    assign accept        = gnt_any && slot_free && !rst;
    assign bus.req_ready = accept ? gnt_onehot : '0;

    assign add_a = bus.req_a[gnt_id*WORD_W +: WORD_W];
    assign add_b = bus.req_b[gnt_id*WORD_W +: WORD_W];

`ifdef ADD_ARB_CARRY_CHAIN_EN
    assign add_cin = (state == ST_LOCK) ? carry_q : bus.req_cin[gnt_id];
`else
    logic unused_cfg;
    assign add_cin    = bus.req_cin[gnt_id];
    assign unused_cfg = ^{bus.req_last, carry_q};
`endif

    adder_16bit u_add (
        .a   (add_a),
        .b   (add_b),
        .Cin (add_cin),
        .y   (add_y),
        .Co  (add_co)
    );

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            lock_id     <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            rsp_co_q    <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= gnt_id;
            rsp_y_q     <= add_y;
            rsp_co_q    <= add_co;
`ifdef ADD_ARB_CARRY_CHAIN_EN
            if (bus.req_last[gnt_id]) begin
                state   <= ST_IDLE;
                carry_q <= 1'b0;
                ptr     <= ID_W'(rr_next(32'(gnt_id), NREQ));
            end else begin
                state   <= ST_LOCK;
                lock_id <= gnt_id;
                carry_q <= add_co;
            end
`else
            ptr <= ID_W'(rr_next(32'(gnt_id), NREQ));
`endif
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_co    = rsp_co_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: per-cycle reference model plus directed literal checks.
module tb_adder_share_arbiter;
    import add_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

    adder_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        last;
    } beat_t;

    typedef struct {
        int          id;
        logic [15:0] y;
        logic        co;
    } rsp_t;

    beat_t bq [NREQ][$];
    rsp_t  log_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester driver: each queue holds beats in order; the head is popped once accepted.
    initial begin
        logic [NREQ-1:0] acc;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && bq[i].size() > 0) void'(bq[i].pop_front());
                if (bq[i].size() > 0) begin
                    bus.req_valid[i]        = 1'b1;
                    bus.req_a[16*i +: 16]   = bq[i][0].a;
                    bus.req_b[16*i +: 16]   = bq[i][0].b;
                    bus.req_cin[i]          = bq[i][0].cin;
                    bus.req_last[i]         = bq[i][0].last;
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Reference model, compared on every falling edge.
    bit          armed = 0;
    logic        m_valid = 0;
    int          m_id = 0;
    logic [15:0] m_y = '0;
    logic        m_co = 0;
    int          m_ptr = 0;
    bit          m_lock = 0;
    int          m_lock_id = 0;
    logic        m_carry = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        bit              found;
        int              g;
        logic            free;
        logic            cin;
        int              sum;
        if (armed) begin
            check("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
            if (m_valid) begin
                check("rsp_id", 64'(bus.rsp_id), 64'(m_id));
                check("rsp_y", 64'(bus.rsp_y), 64'(m_y));
                check("rsp_co", 64'(bus.rsp_co), 64'(m_co));
            end
        end
        found = 0;
        g     = 0;
        if (m_lock) begin
            found = bus.req_valid[m_lock_id];
            g     = m_lock_id;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && bus.req_valid[(m_ptr + k) % NREQ]) begin
                    found = 1;
                    g     = (m_ptr + k) % NREQ;
                end
            end
        end
        free      = !m_valid || bus.rsp_ready;
        exp_ready = (!rst && found && free) ? (NREQ'(1) << g) : '0;
        if (armed) check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        if (armed && !rst && bus.rsp_valid && bus.rsp_ready)
            log_q.push_back('{id: int'(bus.rsp_id), y: bus.rsp_y, co: bus.rsp_co});

        if (rst) begin
            m_valid = 0; m_id = 0; m_y = '0; m_co = 0;
            m_ptr = 0; m_lock = 0; m_lock_id = 0; m_carry = 0;
            armed = 1;
        end else if (exp_ready != '0) begin
            cin = m_lock ? m_carry : bus.req_cin[g];
            sum = int'(bus.req_a[16*g +: 16]) + int'(bus.req_b[16*g +: 16]) + int'(cin);
            m_valid = 1;
            m_id    = g;
            m_y     = sum[15:0];
            m_co    = sum[16];
`ifdef ADD_ARB_CARRY_CHAIN_EN
            if (bus.req_last[g]) begin
                m_lock  = 0;
                m_carry = 0;
                m_ptr   = (g + 1) % NREQ;
            end else begin
                m_lock    = 1;
                m_lock_id = g;
                m_carry   = sum[16];
            end
`else
            m_ptr = (g + 1) % NREQ;
`endif
        end else if (bus.rsp_ready) begin
            m_valid = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic last);
        beat_t t;
        t.a = a; t.b = b; t.cin = cin; t.last = last;
        bq[i].push_back(t);
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += bq[i].size();
        return n;
    endfunction

    task automatic wait_empty();
        int n = 0;
        while (pending() > 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(pending()), 64'(0));
    endtask

    task automatic drain();
        wait_empty();
        step();
        step();
    endtask

    task automatic check_log(input string name, input int idx, input int id,
                             input logic [15:0] y, input logic co);
        rsp_t r;
        r = '{id: -1, y: 16'hxxxx, co: 1'bx};
        if (idx < log_q.size()) r = log_q[idx];
        check({name, "_id"}, 64'(r.id), 64'(id));
        check({name, "_y"}, 64'(r.y), 64'(y));
        check({name, "_co"}, 64'(r.co), 64'(co));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst           = 1'b1;
        bus.rsp_ready = 1'b1;

        // Reset with every requester valid; then fairness 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++)
            repeat (2) push(i, 16'(16'h1111 * (i + 1)), 16'h0100, i[0], 1'b1);
        repeat (4) begin
            step();
            check("rst_req_ready", 64'(bus.req_ready), 64'(0));
            check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        end
        check("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
        check("rst_rsp_y", 64'(bus.rsp_y), 64'(0));
        check("rst_rsp_co", 64'(bus.rsp_co), 64'(0));
        rst = 1'b0;
        drain();
        check_log("fair0", 0, 0, 16'h1211, 1'b0);
        check("fair1_id", 64'(log_q[1].id), 64'(1));
        check("fair2_id", 64'(log_q[2].id), 64'(2));
        check("fair3_id", 64'(log_q[3].id), 64'(3));
        check("fair4_id", 64'(log_q[4].id), 64'(0));

        // Wrap-around and carry-in.
        base = log_q.size();
        push(1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        drain();
        push(3, 16'h1234, 16'h4321, 1'b1, 1'b1);
        drain();
        check_log("wrap", base, 1, 16'h0000, 1'b1);
        check_log("cin", base + 1, 3, 16'h5556, 1'b0);

        // Backpressure: slot held for 5 cycles, release accepts in the same cycle.
        push(0, 16'h000a, 16'h000b, 1'b0, 1'b1);
        wait_empty();
        bus.rsp_ready = 1'b0;
        push(2, 16'h0020, 16'h0030, 1'b0, 1'b1);
        repeat (5) begin
            step();
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
            check("bp_rsp_y", 64'(bus.rsp_y), 64'(16'h0015));
            check("bp_rsp_id", 64'(bus.rsp_id), 64'(0));
            check("bp_req_ready", 64'(bus.req_ready), 64'(0));
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.req_ready), 64'(4'b0100));
        step();
        check("bp_next_id", 64'(bus.rsp_id), 64'(2));
        check("bp_next_y", 64'(bus.rsp_y), 64'(16'h0050));
        drain();

        // Carry chain from requester 2 with 1 and 3 competing; a beat from 1 first puts ptr at 2.
        push(1, 16'h0001, 16'h0001, 1'b0, 1'b1);
        drain();
        base = log_q.size();
        push(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        push(2, 16'h0000, 16'h0000, 1'b0, 1'b1);
        push(3, 16'h0003, 16'h0004, 1'b0, 1'b1);
        push(1, 16'h0010, 16'h0020, 1'b0, 1'b1);
        drain();
        check_log("chain0", base, 2, 16'h0000, 1'b1);
`ifdef ADD_ARB_CARRY_CHAIN_EN
        check_log("chain1", base + 1, 2, 16'h0001, 1'b0);
        check_log("chain2", base + 2, 3, 16'h0007, 1'b0);
        check_log("chain3", base + 3, 1, 16'h0030, 1'b0);
`else
        check_log("chain1", base + 1, 3, 16'h0007, 1'b0);
        check_log("chain2", base + 2, 1, 16'h0030, 1'b0);
        check_log("chain3", base + 3, 2, 16'h0000, 1'b0);
`endif

        // Mid-burst reset while requester 1 holds the chain.
        push(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_empty();
        push(0, 16'h0abc, 16'h0001, 1'b0, 1'b1);
        repeat (3) step();
`ifdef ADD_ARB_CARRY_CHAIN_EN
        check("lock_stall_ready", 64'(bus.req_ready), 64'(0));
        check("lock_stall_pending", 64'(bq[0].size()), 64'(1));
`endif
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) bq[i].delete();
        step();
        step();
        rst = 1'b0;
        check("mrst_state", 64'(dut.state), 64'(ST_IDLE));
        check("mrst_carry", 64'(dut.carry_q), 64'(0));
        base = log_q.size();
        push(1, 16'h0000, 16'h0005, 1'b0, 1'b1);
        drain();
        check_log("mrst_beat", base, 1, 16'h0005, 1'b0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
